softmax_scale_unit: RTL

- Normalisation stage of the approximate-softmax datapath, downstream of the exp/accumulate logic.
- Latches one reciprocal-of-sum scale factor per vector, then streams that vector's exp values through one internal booth instance (16x16 signed radix-4, combinational, 32-bit product).
- Each element is multiplied by the scale, rounded, saturated to 16 bits and emitted.
- Two-stage valid/ready pipeline with a per-vector control FSM.

---
 rtl/softmax_scale_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/softmax_scale_unit.sv
// Softmax normalisation stage: latch a reciprocal-of-sum scale per vector, then
// multiply, round and saturate each element. Optional SOFTMAX_SCALE_SUM_EN adds a per-vector output sum.
module softmax_scale_booth (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [31:0] p
);
  logic [16:0]        bx;
  logic [2:0]         grp;
  logic signed [31:0] pp;

  always_comb begin
    bx  = {b, 1'b0};
    p   = '0;
    grp = '0;
    pp  = '0;
    for (int i = 0; i < 8; i++) begin
      grp = bx[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = {{16{a[15]}}, a};
        3'b011:         pp = {{15{a[15]}}, a, 1'b0};
        3'b100:         pp = -{{15{a[15]}}, a, 1'b0};
        3'b101, 3'b110: pp = -{{16{a[15]}}, a};
        default:        pp = '0;
      endcase
      p = p + (pp <<< (2*i));
    end
  end
endmodule

module softmax_scale_unit #(
  parameter int N       = 16,
  parameter int FRAC    = 15,
  parameter int VEC_LEN = 8,
  parameter int CNT_W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scale_valid,
  output logic         scale_ready,
  input  logic [N-1:0] scale_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
`ifdef SOFTMAX_SCALE_SUM_EN
  ,
  output logic [N+CNT_W-1:0] sum_out,
  output logic               sum_valid
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic signed [2*N:0] HALF = (2*N+1)'(1) <<< (FRAC-1);
  localparam logic signed [2*N:0] MAXV = (2*N+1)'(2**(N-1)-1);
  localparam logic signed [2*N:0] MINV = -(2*N+1)'(2**(N-1));

  state_t             state_q, state_d;
  logic [N-1:0]       scale_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N-1:0]       s1_data;
  logic               s1_valid, s1_last;
  logic               s1_adv, s2_adv, acc, last_tag, out_hs;
  logic signed [2*N-1:0] prod;
  logic signed [2*N:0]   rnd, shr;
  logic [N-1:0]       sat;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = (state_q == RUN) && s1_adv;
  assign acc      = in_valid && in_ready;
  assign last_tag = in_last || (cnt_q == CNT_W'(VEC_LEN-1));
  assign out_hs   = out_valid && out_ready;
  assign scale_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scale_valid) state_d = RUN;
      RUN:     if (acc && last_tag) state_d = DRAIN;
      DRAIN:   if (out_hs && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      scale_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && scale_valid) scale_q <= scale_in;
      if (acc) cnt_q <= last_tag ? '0 : cnt_q + 1'b1;
    end
  end

  softmax_scale_booth u_booth (.a(s1_data), .b(scale_q), .p(prod));

  // Round half up, then clamp into the signed N-bit range.
  always_comb begin
    rnd = {prod[2*N-1], prod} + HALF;
    shr = rnd >>> FRAC;
    if (shr > MAXV)      sat = {1'b0, {(N-1){1'b1}}};
    else if (shr < MINV) sat = {1'b1, {(N-1){1'b0}}};
    else                 sat = shr[N-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= acc;
        if (acc) begin
          s1_data <= in_data;
          s1_last <= last_tag;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= sat;
          out_last <= s1_last;
        end
      end
    end
  end

`ifdef SOFTMAX_SCALE_SUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= out_hs && out_last;
      if (sum_valid)   sum_out <= '0;
      else if (out_hs) sum_out <= sum_out + {{CNT_W{out_data[N-1]}}, out_data};
    end
  end
`endif
endmodule
